// File: rtl/lsu_param_pkg.sv
// Shared encodings for the per-thread load/store unit: LSU state codes and
// the core phase codes it is sequenced by.
package lsu_param_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'd0,
    LSU_REQUESTING = 2'd1,
    LSU_WAITING    = 2'd2,
    LSU_DONE       = 2'd3
  } lsu_state_e;

  localparam logic [2:0] CORE_IDLE      = 3'b000;
  localparam logic [2:0] CORE_FETCH     = 3'b001;
  localparam logic [2:0] CORE_DECODE    = 3'b010;
  localparam logic [2:0] CORE_REQUEST   = 3'b011;
  localparam logic [2:0] CORE_WAIT      = 3'b100;
  localparam logic [2:0] CORE_EXECUTE   = 3'b101;
  localparam logic [2:0] CORE_WRITEBACK = 3'b110;
  localparam logic [2:0] CORE_DONE      = 3'b111;

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Wait-cycle counter for the LSU: cleared at request issue, counts enabled
// waiting cycles, and flags the last permitted cycle.
module lsu_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMO_W          = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam logic [TMO_W-1:0] LP_LAST =
    (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit LP_ACTIVE = (TIMEOUT_CYCLES > 0);

  logic [TMO_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // A zero timeout disables the abort entirely; the count is then irrelevant.
  assign o_expired = LP_ACTIVE && (r_count == LP_LAST);

endmodule

// File: rtl/lsu_param.sv
// Per-thread load/store unit: one valid/ready data-memory channel per direction,
// base+offset addressing, wait timeout and illegal read+write detection.
module lsu_param
  import lsu_param_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMO_W          = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        core_state,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  input  logic [ADDR_W-1:0] mem_offset,
  output logic              mem_read_request,
  output logic [ADDR_W-1:0] mem_read_address,
  input  logic              mem_read_ready,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              mem_write_request,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic              mem_write_ready,
  output logic [1:0]        lsu_state,
  output logic [DATA_W-1:0] lsu_out,
  output logic              lsu_error
);

  lsu_state_e        r_state;
  logic              r_is_write;
  logic              r_rd_req;
  logic              r_wr_req;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_out;
  logic              r_err;

  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_addr;
  logic              w_ready;
  logic              w_expired;
  logic              w_ctr_clear;
  logic              w_ctr_inc;

  // The base register is narrowed or zero-extended to the address width.
  generate
    if (DATA_W >= ADDR_W) begin : g_base_trunc
      assign w_base = rs[ADDR_W-1:0];
    end else begin : g_base_zext
      assign w_base = {{(ADDR_W-DATA_W){1'b0}}, rs};
    end
  endgenerate

  assign w_addr  = w_base + mem_offset;
  assign w_ready = r_is_write ? mem_write_ready : mem_read_ready;

  assign w_ctr_clear = enable && (r_state == LSU_REQUESTING);
  assign w_ctr_inc   = enable && (r_state == LSU_WAITING) && !w_ready;

  lsu_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMO_W          (TMO_W)
  ) u_timeout_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_ctr_clear),
    .i_count_en (w_ctr_inc),
    .o_expired  (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= LSU_IDLE;
      r_is_write <= 1'b0;
      r_rd_req   <= 1'b0;
      r_wr_req   <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_out      <= '0;
      r_err      <= 1'b0;
    end else if (enable) begin
      case (r_state)
        LSU_IDLE: begin
          if (core_state == CORE_REQUEST) begin
            if (MemRead && MemWrite) begin
              r_err   <= 1'b1;
              r_state <= LSU_DONE;
            end else if (MemRead ^ MemWrite) begin
              r_err      <= 1'b0;
              r_is_write <= MemWrite;
              r_state    <= LSU_REQUESTING;
            end
          end
        end
        LSU_REQUESTING: begin
          // Only the active channel's address moves; the other keeps its last value.
          if (r_is_write) begin
            r_wr_addr <= w_addr;
            r_wr_data <= rt;
            r_wr_req  <= 1'b1;
          end else begin
            r_rd_addr <= w_addr;
            r_rd_req  <= 1'b1;
          end
          r_state <= LSU_WAITING;
        end
        LSU_WAITING: begin
          if (w_ready) begin
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            if (!r_is_write) begin
              r_out <= mem_read_data;
            end
            r_state <= LSU_DONE;
          end else if (w_expired) begin
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_err    <= 1'b1;
            r_state  <= LSU_DONE;
          end
        end
        LSU_DONE: begin
          if (core_state == CORE_WRITEBACK) begin
            r_state <= LSU_IDLE;
          end
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  assign mem_read_request  = r_rd_req;
  assign mem_read_address  = r_rd_addr;
  assign mem_write_request = r_wr_req;
  assign mem_write_address = r_wr_addr;
  assign mem_write_data    = r_wr_data;
  assign lsu_state         = r_state;
  assign lsu_out           = r_out;
  assign lsu_error         = r_err;

endmodule

// File: tb/tb_lsu_param.sv
// Scoreboard bench for lsu_param: directed accesses push expected completions,
// a negedge monitor checks each entry into DONE.
module tb_lsu_param;
  import lsu_param_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] core_state;
  logic       MemRead, MemWrite;
  logic [7:0] rs, rt, mem_offset;
  logic       mem_read_request;
  logic [7:0] mem_read_address;
  logic       mem_read_ready;
  logic [7:0] mem_read_data;
  logic       mem_write_request;
  logic [7:0] mem_write_address;
  logic [7:0] mem_write_data;
  logic       mem_write_ready;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;
  logic       lsu_error;

  always #5 clk = ~clk;

  lsu_param #(
    .DATA_W(8), .ADDR_W(8), .TIMEOUT_CYCLES(4), .TMO_W(3)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .MemRead(MemRead), .MemWrite(MemWrite), .rs(rs), .rt(rt),
    .mem_offset(mem_offset),
    .mem_read_request(mem_read_request), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_request(mem_write_request), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_error(lsu_error)
  );

  typedef struct {
    string      name;
    logic [7:0] out;
    logic       err;
    logic [7:0] rd_addr;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    int         rd_cyc;
    int         wr_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input string name, input logic [7:0] out, input logic err,
                          input logic [7:0] rda, input logic [7:0] wra,
                          input logic [7:0] wrd, input int rc, input int wc);
    exp_t e;
    e.name = name; e.out = out; e.err = err; e.rd_addr = rda;
    e.wr_addr = wra; e.wr_data = wrd; e.rd_cyc = rc; e.wr_cyc = wc;
    exp_q.push_back(e);
  endtask

  // Monitor: counts request-high cycles per access, compares on entry to DONE.
  logic [1:0] mon_prev = 2'd0;
  int         mon_rc = 0;
  int         mon_wc = 0;
  logic       mon_both = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      mon_rc = 0; mon_wc = 0; mon_both = 1'b0;
    end else begin
      if (mem_read_request)  mon_rc++;
      if (mem_write_request) mon_wc++;
      if (mem_read_request && mem_write_request) mon_both = 1'b1;
      if (lsu_state == 2'd3 && mon_prev != 2'd3) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk({e.name, "_out"},     lsu_out, e.out);
          chk({e.name, "_err"},     lsu_error, e.err);
          chk({e.name, "_rd_addr"}, mem_read_address, e.rd_addr);
          chk({e.name, "_wr_addr"}, mem_write_address, e.wr_addr);
          chk({e.name, "_wr_data"}, mem_write_data, e.wr_data);
          chk({e.name, "_rd_cyc"},  mon_rc, e.rd_cyc);
          chk({e.name, "_wr_cyc"},  mon_wc, e.wr_cyc);
          chk({e.name, "_excl"},    mon_both, 1'b0);
          $display("txn %s: out=%02h err=%0b rd_addr=%02h wr_addr=%02h wr_data=%02h rd_cyc=%0d wr_cyc=%0d",
                   e.name, lsu_out, lsu_error, mem_read_address, mem_write_address,
                   mem_write_data, mon_rc, mon_wc);
        end
        mon_rc = 0; mon_wc = 0; mon_both = 1'b0;
      end
    end
    mon_prev = lsu_state;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ready_after: WAITING cycle on which ready is given (0 = never).
  // freeze_at: WAITING cycle before which enable drops for 5 cycles (0 = none).
  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [7:0] base, input logic [7:0] data,
                        input logic [7:0] off, input int ready_after,
                        input int freeze_at, input logic noise,
                        input logic [7:0] rdata);
    int k;
    core_state = CORE_REQUEST; MemRead = rd; MemWrite = wr;
    rs = base; rt = data; mem_offset = off;
    step();
    core_state = CORE_WAIT;
    if (rd && wr) begin
      chk({name, "_illegal_state"}, lsu_state, 2'd3);
      MemRead = 1'b0; MemWrite = 1'b0;
    end else begin
      chk({name, "_req_state"}, lsu_state, 2'd1);
      chk({name, "_err_clear"}, lsu_error, 1'b0);
      step();
      // Flip the decode to the opposite op; the latched type must stay.
      MemRead = wr; MemWrite = rd; rs = 8'hEE; rt = 8'hEE; mem_offset = 8'hEE;
      chk({name, "_wait_state"}, lsu_state, 2'd2);
      chk({name, "_req_high"}, rd ? mem_read_request : mem_write_request, 1'b1);
      k = 1;
      while (lsu_state != 2'd3 && k <= 20) begin
        if (k == freeze_at) begin
          enable = 1'b0;
          repeat (5) begin
            step();
            chk({name, "_frozen"}, lsu_state, 2'd2);
          end
          enable = 1'b1;
        end
        if (noise) begin
          if (rd) mem_write_ready = 1'b1;
          else    mem_read_ready  = 1'b1;
        end
        if (k == ready_after) begin
          if (rd) begin
            mem_read_ready = 1'b1; mem_read_data = rdata;
          end else begin
            mem_write_ready = 1'b1;
          end
        end
        step();
        mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = 8'hC3;
        k++;
      end
      chk({name, "_reached_done"}, lsu_state, 2'd3);
      MemRead = 1'b0; MemWrite = 1'b0;
    end
    step();
    chk({name, "_done_hold"}, lsu_state, 2'd3);
    core_state = CORE_WRITEBACK;
    step();
    chk({name, "_back_idle"}, lsu_state, 2'd0);
    core_state = CORE_IDLE;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; core_state = CORE_IDLE;
    MemRead = 1'b0; MemWrite = 1'b0; rs = 8'h00; rt = 8'h00; mem_offset = 8'h00;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = 8'hC3;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_state",    lsu_state, 2'd0);
    chk("rst_rd_req",   mem_read_request, 1'b0);
    chk("rst_wr_req",   mem_write_request, 1'b0);
    chk("rst_rd_addr",  mem_read_address, 8'h00);
    chk("rst_wr_addr",  mem_write_address, 8'h00);
    chk("rst_wr_data",  mem_write_data, 8'h00);
    chk("rst_out",      lsu_out, 8'h00);
    chk("rst_err",      lsu_error, 1'b0);
    step();

    push_exp("load0",   8'hA5, 1'b0, 8'h15, 8'h00, 8'h00, 1, 0);
    access("load0", 1'b1, 1'b0, 8'h10, 8'h00, 8'h05, 1, 0, 1'b0, 8'hA5);
    push_exp("store3",  8'hA5, 1'b0, 8'h15, 8'h20, 8'h3C, 0, 3);
    access("store3", 1'b0, 1'b1, 8'h20, 8'h3C, 8'h00, 3, 0, 1'b1, 8'h00);
    push_exp("wrap",    8'h5A, 1'b0, 8'h01, 8'h20, 8'h3C, 2, 0);
    access("wrap", 1'b1, 1'b0, 8'hFF, 8'h00, 8'h02, 2, 0, 1'b0, 8'h5A);
    push_exp("timeout", 8'h5A, 1'b1, 8'h31, 8'h20, 8'h3C, 4, 0);
    access("timeout", 1'b1, 1'b0, 8'h30, 8'h00, 8'h01, 0, 0, 1'b0, 8'h00);
    push_exp("reload",  8'h77, 1'b0, 8'h40, 8'h20, 8'h3C, 1, 0);
    access("reload", 1'b1, 1'b0, 8'h40, 8'h00, 8'h00, 1, 0, 1'b0, 8'h77);
    push_exp("illegal", 8'h77, 1'b1, 8'h40, 8'h20, 8'h3C, 0, 0);
    access("illegal", 1'b1, 1'b1, 8'h90, 8'h11, 8'h00, 0, 0, 1'b0, 8'h00);
    push_exp("freeze",  8'h77, 1'b0, 8'h40, 8'h53, 8'h99, 0, 8);
    access("freeze", 1'b0, 1'b1, 8'h50, 8'h99, 8'h03, 3, 3, 1'b0, 8'h00);

    // Reset in the middle of a wait, then a stray ready.
    core_state = CORE_REQUEST; MemRead = 1'b1; rs = 8'h60; mem_offset = 8'h00;
    step();
    step();
    core_state = CORE_WAIT; MemRead = 1'b0;
    chk("rstmid_req_high", mem_read_request, 1'b1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_state",   lsu_state, 2'd0);
    chk("rstmid_rd_req",  mem_read_request, 1'b0);
    chk("rstmid_rd_addr", mem_read_address, 8'h00);
    chk("rstmid_wr_addr", mem_write_address, 8'h00);
    chk("rstmid_wr_data", mem_write_data, 8'h00);
    chk("rstmid_out",     lsu_out, 8'h00);
    chk("rstmid_err",     lsu_error, 1'b0);
    mem_read_ready = 1'b1; mem_read_data = 8'hBE;
    step();
    mem_read_ready = 1'b0;
    chk("stray_state",  lsu_state, 2'd0);
    chk("stray_rd_req", mem_read_request, 1'b0);
    chk("stray_out",    lsu_out, 8'h00);
    $display("txn reset_mid_wait: state=%0d rd_req=%0b out=%02h", lsu_state, mem_read_request, lsu_out);

    step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
